// File: rtl/qspi_axil_pkg.sv
// Shared definitions for the QSPI AXI4-Lite register front-end:
// register indices, field positions, response codes and the byte-strobe merge.
package qspi_axil_pkg;

    localparam int AXI_DATA_WIDTH = 32;

    // Word index (low two bits; higher index bits must be zero for a hit)
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CFG    = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;

    // STATUS bit positions
    localparam int ST_WIP  = 0;
    localparam int ST_RXV  = 1;
    localparam int ST_TXB  = 2;
    localparam int ST_DONE = 3;

    // CFG bit positions
    localparam int CFG_READ    = 0;
    localparam int CFG_WRITE   = 1;
    localparam int CFG_AMODE   = 2;
    localparam int CFG_IRQEN   = 3;
    localparam int CFG_CNT_LSB = 8;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Replace only the strobed bytes of old_v with new_v
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/qspi_tx_unpacker.sv
// Splits one 32-bit TX word into bytes for the QSPI TX FIFO. Mode 0 sends
// all four bytes LSB first; mode 1 sends a 24-bit address MSB first.
module qspi_tx_unpacker
    import qspi_axil_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        amode_i,
    input  logic        tx_full_i,
    output logic        busy_o,
    output logic        tx_wr_o,
    output logic [7:0]  tx_byte_o,
    output logic        last_o,
    output logic        amode_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;
    logic        busy_q;
    logic        amode_q;

    logic [1:0]  lane;
    logic        is_last;
    logic        push;

    // Select the byte lane for the current push and detect the final byte
    always_comb begin
        lane      = amode_q ? (2'd2 - cnt_q) : cnt_q;
        is_last   = amode_q ? (cnt_q == 2'd2) : (cnt_q == 2'd3);
        push      = busy_q & ~tx_full_i;
        tx_byte_o = busy_q ? word_q[{lane, 3'b000} +: 8] : 8'h00;
    end

    assign busy_o  = busy_q;
    assign tx_wr_o = push;
    assign last_o  = push & is_last;
    assign amode_o = amode_q;

    // Load a word, then advance one byte per accepted push; a full FIFO holds the index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            amode_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            amode_q <= amode_i;
        end else if (push) begin
            if (is_last) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/axil_qspi_regs.sv
// AXI4-Lite register front-end for the QSPI engine: STATUS/CFG/TXDATA/RXDATA,
// independent AW/W holding slots, TX word unpacking and RX byte packing.
module axil_qspi_regs
    import qspi_axil_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rx_empty,
    input  logic [7:0]                i_rx_byte,
    output logic                      o_rx_rd,
    input  logic                      i_tx_full,
    output logic                      o_tx_wr,
    output logic [7:0]                o_tx_byte,
    input  logic                      i_wip,
    input  logic                      i_complete,
    output logic                      o_read,
    output logic                      o_write,
    output logic [CNT_WIDTH-1:0]      o_byte_count,
    output logic                      o_irq,
    input  logic                      i_awvalid,
    output logic                      o_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_awaddr,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    input  logic [31:0]               i_wdata,
    input  logic [3:0]                i_wstrb,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    output logic [1:0]                o_bresp,
    input  logic                      i_arvalid,
    output logic                      o_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_araddr,
    output logic                      o_rvalid,
    input  logic                      i_rready,
    output logic [31:0]               o_rdata,
    output logic [1:0]                o_rresp
);

    localparam int IW = AXI_ADDR_WIDTH - 2;

    logic          aw_full_q, w_full_q;
    logic [IW-1:0] aw_idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          bvalid_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic          wip_q, done_q, rx_valid_q;
    logic [2:0]    fill_q;
    logic [31:0]   rx_word_q;
    logic          cfg_read_q, cfg_write_q, cfg_amode_q, cfg_irqen_q;
    logic [CNT_WIDTH-1:0] cfg_cnt_q;
    logic [31:0]   txdata_q;

    logic          aw_hs, w_hs, ar_hs, wr_exec;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [1:0]    wr_resp, rd_resp;
    logic [31:0]   rd_data, cfg_rd, cfg_d, txdata_d, status_rd;
    logic          cfg_we, tx_load, done_clr, rx_read_clr, rx_pop;
    logic          tx_busy, tx_last, tx_amode;

    assign o_awready    = ~aw_full_q;
    assign o_wready     = ~w_full_q;
    assign o_arready    = ~rvalid_q;
    assign o_bvalid     = bvalid_q;
    assign o_bresp      = bresp_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_rresp      = rresp_q;
    assign o_read       = cfg_read_q;
    assign o_write      = cfg_write_q;
    assign o_byte_count = cfg_cnt_q;
    assign o_irq        = done_q & cfg_irqen_q;
    assign rx_pop       = ~rx_valid_q & ~i_rx_empty;
    assign o_rx_rd      = rx_pop;

    logic unused_bits;
    assign unused_bits = ^{i_awaddr[1:0], i_araddr[1:0], cfg_d};

    qspi_tx_unpacker u_tx (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tx_load),
        .word_i    (txdata_d),
        .amode_i   (cfg_amode_q),
        .tx_full_i (i_tx_full),
        .busy_o    (tx_busy),
        .tx_wr_o   (o_tx_wr),
        .tx_byte_o (o_tx_byte),
        .last_o    (tx_last),
        .amode_o   (tx_amode)
    );

    // Current register images and strobe-merged write values
    always_comb begin
        cfg_rd = '0;
        cfg_rd[CFG_READ]  = cfg_read_q;
        cfg_rd[CFG_WRITE] = cfg_write_q;
        cfg_rd[CFG_AMODE] = cfg_amode_q;
        cfg_rd[CFG_IRQEN] = cfg_irqen_q;
        cfg_rd[CFG_CNT_LSB +: CNT_WIDTH] = cfg_cnt_q;
        status_rd = '0;
        status_rd[ST_WIP]  = wip_q;
        status_rd[ST_RXV]  = rx_valid_q;
        status_rd[ST_TXB]  = tx_busy;
        status_rd[ST_DONE] = done_q;
        aw_hs    = i_awvalid & ~aw_full_q;
        w_hs     = i_wvalid & ~w_full_q;
        wr_idx   = aw_full_q ? aw_idx_q : i_awaddr[AXI_ADDR_WIDTH-1:2];
        wr_data  = w_full_q ? wdata_q : i_wdata;
        wr_strb  = w_full_q ? wstrb_q : i_wstrb;
        wr_exec  = (aw_full_q | aw_hs) & (w_full_q | w_hs) & (~bvalid_q | i_bready);
        cfg_d    = wstrb_merge(cfg_rd, wr_data, wr_strb);
        txdata_d = wstrb_merge(txdata_q, wr_data, wr_strb);
    end

    // Write decode: response code plus the side effect it is allowed to have
    always_comb begin
        wr_resp  = RESP_OKAY;
        cfg_we   = 1'b0;
        tx_load  = 1'b0;
        done_clr = 1'b0;
        if (wr_idx[IW-1:2] != '0) begin
            wr_resp = RESP_DECERR;
        end else begin
            case (wr_idx[1:0])
                REG_STATUS: begin
                    if ((wr_data & strb_mask(wr_strb) & ~32'h8) != '0) wr_resp = RESP_SLVERR;
                    else done_clr = wr_exec & wr_data[ST_DONE] & wr_strb[0];
                end
                REG_CFG: begin
                    if (cfg_read_q | cfg_write_q) wr_resp = RESP_SLVERR;
                    else cfg_we = wr_exec;
                end
                REG_TXDATA: begin
                    if (tx_busy) wr_resp = RESP_SLVERR;
                    else tx_load = wr_exec;
                end
                default: wr_resp = RESP_SLVERR;  // RXDATA is read-only
            endcase
        end
    end

    // Read decode against the pre-write register state
    always_comb begin
        rd_idx      = i_araddr[AXI_ADDR_WIDTH-1:2];
        ar_hs       = i_arvalid & ~rvalid_q;
        rd_data     = '0;
        rd_resp     = RESP_OKAY;
        rx_read_clr = 1'b0;
        if (rd_idx[IW-1:2] != '0) begin
            rd_resp = RESP_DECERR;
        end else begin
            case (rd_idx[1:0])
                REG_STATUS: rd_data = status_rd;
                REG_CFG:    rd_data = cfg_rd;
                REG_TXDATA: rd_data = txdata_q;
                default: begin
                    if (rx_valid_q) begin
                        rd_data     = rx_word_q;
                        rx_read_clr = ar_hs;
                    end else begin
                        rd_resp     = RESP_SLVERR;
                    end
                end
            endcase
        end
    end

    // Write path: holding slots, write response and register-file updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            cfg_read_q  <= 1'b0;
            cfg_write_q <= 1'b0;
            cfg_amode_q <= 1'b0;
            cfg_irqen_q <= 1'b0;
            cfg_cnt_q   <= '0;
            txdata_q    <= '0;
            done_q      <= 1'b0;
            wip_q       <= 1'b0;
        end else begin
            if (wr_exec) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full_q <= 1'b1;
                    aw_idx_q  <= i_awaddr[AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_full_q <= 1'b1;
                    wdata_q  <= i_wdata;
                    wstrb_q  <= i_wstrb;
                end
            end
            if (wr_exec) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (i_bready) begin
                bvalid_q <= 1'b0;
            end
            if (cfg_we) begin
                cfg_read_q  <= cfg_d[CFG_READ];
                cfg_write_q <= cfg_d[CFG_WRITE];
                cfg_amode_q <= cfg_d[CFG_AMODE];
                cfg_irqen_q <= cfg_d[CFG_IRQEN];
                cfg_cnt_q   <= cfg_d[CFG_CNT_LSB +: CNT_WIDTH];
            end
            // Address-mode is a one-shot: it drops once the 3-byte address is out
            if (tx_last && tx_amode) cfg_amode_q <= 1'b0;
            if (i_complete) begin
                cfg_read_q  <= 1'b0;
                cfg_write_q <= 1'b0;
            end
            if (tx_load) txdata_q <= txdata_d;
            // Completion set beats a simultaneous W1C
            if (i_complete) done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
            wip_q <= i_wip;
        end
    end

    // Read path: register data/response on accept, hold until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (i_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // RX packing: pop bytes LSB first until a word is full or the transfer ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            fill_q     <= '0;
            rx_word_q  <= '0;
        end else if (rx_read_clr) begin
            rx_valid_q <= 1'b0;
            fill_q     <= '0;
            rx_word_q  <= '0;
        end else if (!rx_valid_q) begin
            if (rx_pop) begin
                rx_word_q[{fill_q[1:0], 3'b000} +: 8] <= i_rx_byte;
                fill_q <= fill_q + 3'd1;
                if (fill_q == 3'd3 || i_complete) rx_valid_q <= 1'b1;
            end else if (i_complete && fill_q != 3'd0) begin
                rx_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_qspi_regs.sv
module tb_axil_qspi_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rx_empty = 1'b1;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        o_rx_rd;
    logic        i_tx_full = 1'b0;
    logic        o_tx_wr;
    logic [7:0]  o_tx_byte;
    logic        i_wip = 1'b0;
    logic        i_complete = 1'b0;
    logic        o_read, o_write, o_irq;
    logic [7:0]  o_byte_count;
    logic        i_awvalid = 1'b0;
    logic        o_awready;
    logic [4:0]  i_awaddr = '0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        o_bvalid;
    logic        i_bready = 1'b1;
    logic [1:0]  o_bresp;
    logic        i_arvalid = 1'b0;
    logic        o_arready;
    logic [4:0]  i_araddr = '0;
    logic        o_rvalid;
    logic        i_rready = 1'b1;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;

    axil_qspi_regs #(.AXI_ADDR_WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i_rx_empty(i_rx_empty), .i_rx_byte(i_rx_byte), .o_rx_rd(o_rx_rd),
        .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_byte(o_tx_byte),
        .i_wip(i_wip), .i_complete(i_complete),
        .o_read(o_read), .o_write(o_write), .o_byte_count(o_byte_count), .o_irq(o_irq),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int tx_viol = 0;
    logic [7:0] txq[$];

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [17];

    // TX FIFO observer: samples just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (!rst && o_tx_wr) begin
            txq.push_back(o_tx_byte);
            if (i_tx_full) tx_viol++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        total_cnt++;
        $display("FAIL %s: got timeout required handshake", nm);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_d, w_d;
        int n;
        @(negedge clk);
        i_awvalid = 1'b1; i_awaddr = a;
        i_wvalid = 1'b1; i_wdata = d; i_wstrb = s;
        aw_d = 0; w_d = 0; n = 0;
        while (!(aw_d && w_d) && n < 20) begin
            if (i_awvalid && o_awready) aw_d = 1;
            if (i_wvalid && o_wready) w_d = 1;
            @(negedge clk);
            n++;
            if (aw_d) i_awvalid = 1'b0;
            if (w_d) i_wvalid = 1'b0;
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        n = 0;
        while (!o_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_bvalid) begin
            tmo("bvalid");
            resp = 2'b01;
        end else begin
            resp = o_bresp;
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        i_arvalid = 1'b1; i_araddr = a;
        n = 0;
        while (!o_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        i_arvalid = 1'b0;
        n = 0;
        while (!o_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_rvalid) begin
            tmo("rvalid");
            d = 32'hDEAD_BEEF; resp = 2'b01;
        end else begin
            d = o_rdata; resp = o_rresp;
        end
    endtask

    task automatic chk_tx(input string nm, input int base, input logic [7:0] exp [4], input int n);
        logic [7:0] got;
        chk({nm, " count"}, 32'(txq.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (base + i < txq.size()) ? txq[base + i] : 8'h00;
            chk($sformatf("%s byte%0d", nm, i), {24'h0, got}, {24'h0, exp[i]});
        end
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic [31:0] d;
        logic [1:0] r;
        axi_read(a, d, r);
        chk({nm, " rdata"}, d, ed);
        chk({nm, " rresp"}, {30'h0, r}, {30'h0, er});
    endtask

    task automatic wr_chk(input string nm, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
        logic [1:0] r;
        axi_write(a, d, s, r);
        chk({nm, " bresp"}, {30'h0, r}, {30'h0, er});
    endtask

    initial begin
        int base;

        // Register-map vectors
        tbl[0]  = '{1'b0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[1]  = '{1'b0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[2]  = '{1'b0, 5'h08, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[3]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 2'b10, 32'h0};
        tbl[4]  = '{1'b0, 5'h14, 32'h0,        4'h0, 2'b11, 32'h0};
        tbl[5]  = '{1'b0, 5'h1C, 32'h0,        4'h0, 2'b11, 32'h0};
        tbl[6]  = '{1'b1, 5'h18, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
        tbl[7]  = '{1'b1, 5'h00, 32'h00000001, 4'hF, 2'b10, 32'h0};
        tbl[8]  = '{1'b1, 5'h00, 32'h00000008, 4'hF, 2'b00, 32'h0};
        tbl[9]  = '{1'b1, 5'h04, 32'h00003304, 4'h2, 2'b00, 32'h0};
        tbl[10] = '{1'b0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h00003300};
        tbl[11] = '{1'b1, 5'h04, 32'hFFFFFF08, 4'h1, 2'b00, 32'h0};
        tbl[12] = '{1'b0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h00003308};
        tbl[13] = '{1'b1, 5'h04, 32'h00000000, 4'hF, 2'b00, 32'h0};
        tbl[14] = '{1'b0, 5'h04, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[15] = '{1'b1, 5'h00, 32'h00000100, 4'h1, 2'b00, 32'h0};
        tbl[16] = '{1'b0, 5'h00, 32'h0,        4'h0, 2'b00, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst bvalid", {31'h0, o_bvalid}, 32'h0);
        chk("rst rvalid", {31'h0, o_rvalid}, 32'h0);
        chk("rst tx_wr", {31'h0, o_tx_wr}, 32'h0);
        chk("rst irq", {31'h0, o_irq}, 32'h0);
        chk("rst cfg outs", {22'h0, o_read, o_write, o_byte_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) wr_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].resp);
            else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rdata, tbl[i].resp);
        end

        // AW early, W three cycles later: response one cycle after W
        @(negedge clk);
        i_awvalid = 1'b1; i_awaddr = 5'h04;
        @(negedge clk);
        i_awvalid = 1'b0;
        chk("aw slot held awready", {31'h0, o_awready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        i_wvalid = 1'b1; i_wdata = 32'h00000A0B; i_wstrb = 4'hF;
        chk("bvalid before W", {31'h0, o_bvalid}, 32'h0);
        @(negedge clk);
        i_wvalid = 1'b0;
        chk("split write bvalid", {31'h0, o_bvalid}, 32'h1);
        chk("split write bresp", {30'h0, o_bresp}, 32'h0);
        chk("split write outs", {22'h0, o_read, o_write, o_byte_count}, 32'h30A);
        chk("slots free", {30'h0, o_awready, o_wready}, 32'h3);
        rd_chk("cfg after split", 5'h04, 32'h00000A0B, 2'b00);

        // CFG locked while a transfer is configured
        wr_chk("cfg busy", 5'h04, 32'h0, 4'hF, 2'b10);
        rd_chk("cfg unchanged", 5'h04, 32'h00000A0B, 2'b00);

        // Completion clears read/write and raises done/irq
        @(negedge clk); i_complete = 1'b1;
        @(negedge clk); i_complete = 1'b0;
        chk("complete outs", {30'h0, o_read, o_write}, 32'h0);
        chk("complete irq", {31'h0, o_irq}, 32'h1);
        rd_chk("cfg after complete", 5'h04, 32'h00000A08, 2'b00);
        wr_chk("w1c done", 5'h00, 32'h8, 4'hF, 2'b00);
        chk("irq after w1c", {31'h0, o_irq}, 32'h0);

        // Mode-0 unpack with mid-word backpressure
        base = txq.size();
        wr_chk("txdata", 5'h08, 32'h44332211, 4'hF, 2'b00);
        @(negedge clk);
        i_tx_full = 1'b1;
        wr_chk("txdata busy", 5'h08, 32'h00000055, 4'hF, 2'b10);
        repeat (2) @(negedge clk);
        i_tx_full = 1'b0;
        repeat (8) @(negedge clk);
        chk_tx("mode0", base, '{8'h11, 8'h22, 8'h33, 8'h44}, 4);
        chk("no push while full", 32'(tx_viol), 32'h0);
        rd_chk("txdata readback", 5'h08, 32'h44332211, 2'b00);
        rd_chk("status idle", 5'h00, 32'h0, 2'b00);

        // Mode-1 three-byte address, addr_mode self-clears
        wr_chk("cfg amode", 5'h04, 32'h00000A0C, 4'hF, 2'b00);
        base = txq.size();
        wr_chk("txdata addr", 5'h08, 32'h00ABCDEF, 4'hF, 2'b00);
        repeat (8) @(negedge clk);
        chk_tx("mode1", base, '{8'hAB, 8'hCD, 8'hEF, 8'h00}, 3);
        rd_chk("cfg amode cleared", 5'h04, 32'h00000A08, 2'b00);

        // RX partial word closed by completion
        @(negedge clk);
        i_rx_empty = 1'b0; i_rx_byte = 8'hDE;
        #1 chk("rx pop", {31'h0, o_rx_rd}, 32'h1);
        @(negedge clk);
        i_rx_byte = 8'hAD;
        @(negedge clk);
        i_rx_empty = 1'b1;
        @(negedge clk);
        i_complete = 1'b1; i_wip = 1'b1;
        @(negedge clk);
        i_complete = 1'b0;
        i_rx_empty = 1'b0;
        #1 chk("no pop while rx_valid", {31'h0, o_rx_rd}, 32'h0);
        i_rx_empty = 1'b1;
        rd_chk("status rx done", 5'h00, 32'h0000000B, 2'b00);
        i_wip = 1'b0;
        chk("irq rx", {31'h0, o_irq}, 32'h1);
        rd_chk("rxdata", 5'h0C, 32'h0000ADDE, 2'b00);
        rd_chk("rxdata again", 5'h0C, 32'h0, 2'b10);
        wr_chk("w1c done2", 5'h00, 32'h8, 4'hF, 2'b00);
        chk("irq cleared", {31'h0, o_irq}, 32'h0);

        // W1C coinciding with completion: set wins
        @(negedge clk);
        i_awvalid = 1'b1; i_awaddr = 5'h00;
        i_wvalid = 1'b1; i_wdata = 32'h8; i_wstrb = 4'hF;
        i_complete = 1'b1;
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_complete = 1'b0;
        chk("w1c+complete bvalid", {31'h0, o_bvalid}, 32'h1);
        rd_chk("done set wins", 5'h00, 32'h00000008, 2'b00);

        // Reset in the middle of a TX word
        wr_chk("cfg mode0", 5'h04, 32'h00000A08, 4'hF, 2'b00);
        base = txq.size();
        wr_chk("txdata pre-rst", 5'h08, 32'h04030201, 4'hF, 2'b00);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid-rst pushes", 32'(txq.size() - base), 32'h2);
        chk("mid-rst tx", {23'h0, o_tx_wr, o_tx_byte}, 32'h0);
        chk("mid-rst outs", {20'h0, o_irq, o_bvalid, o_read, o_write, o_byte_count}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post-rst pushes", 32'(txq.size() - base), 32'h2);
        rd_chk("status after rst", 5'h00, 32'h0, 2'b00);
        rd_chk("cfg after rst", 5'h04, 32'h0, 2'b00);
        rd_chk("txdata after rst", 5'h08, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
